dec_scan: RTL and testbench

DEC_SCAN -- requirements
Module: dec_scan

---
 rtl/dec_pkg.sv | 13 +
 rtl/dec_onehot.sv | 17 +
 rtl/dec_scan.sv | 123 ++++++++++++
 tb/tb_dec_scan.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared definitions for the dec_scan decoder/scanner: FSM states and mode encodings.
package dec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_onehot.sv
// Combinational N-to-2^N one-hot decoder; all-zero output when disabled.
module dec_onehot #(
    parameter int N = 2
) (
    input  logic [N-1:0]      sel,
    input  logic              en,
    output logic [(1<<N)-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_scan.sv
// One-hot decoder with direct (handshaked select) and auto-scan modes.
// Output y is registered from the decode of the next index, so it is always one-hot or zero.
module dec_scan
    import dec_pkg::*;
#(
    parameter int N     = 2,
    parameter int DWELL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      i,
    output logic [(1<<N)-1:0] y,
    output logic [N-1:0]      idx,
    output logic              wrap,
    output logic              busy
);

    localparam int          W          = 1 << N;
    localparam logic [7:0]  DWELL_LAST = 8'(DWELL - 1);
    localparam logic [N-1:0] IDX_LAST  = '1;

    state_t         r_state;
    logic [W-1:0]   r_y;
    logic [N-1:0]   r_idx;
    logic [7:0]     r_cnt;
    logic           r_wrap;

    state_t         w_nextState;
    logic [N-1:0]   w_nextIdx;
    logic           w_nextOn;
    logic [7:0]     w_nextCnt;
    logic           w_nextWrap;
    logic [W-1:0]   w_y;

    assign in_ready = (r_state == ST_DIRECT);
    assign busy     = (r_state == ST_SCAN);
    assign y        = r_y;
    assign idx      = r_idx;
    assign wrap     = r_wrap;

    // Whenever the output goes dark the index is forced to 0, so idx tracks y.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        w_nextOn    = |r_y;
        w_nextCnt   = r_cnt;
        w_nextWrap  = 1'b0;
        if (!en) begin
            w_nextState = ST_IDLE;
            w_nextIdx   = '0;
            w_nextOn    = 1'b0;
            w_nextCnt   = '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DIRECT: begin
                    if (mode == MODE_SCAN) begin
                        w_nextState = ST_SCAN;
                        w_nextIdx   = '0;
                        w_nextOn    = 1'b1;
                        w_nextCnt   = '0;
                    end else if (r_state == ST_IDLE) begin
                        w_nextState = ST_DIRECT;
                        w_nextIdx   = '0;
                        w_nextOn    = 1'b0;
                        w_nextCnt   = '0;
                    end else if (in_valid) begin
                        w_nextIdx = i;
                        w_nextOn  = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (mode == MODE_DIRECT) begin
                        w_nextState = ST_DIRECT;
                        w_nextIdx   = '0;
                        w_nextOn    = 1'b0;
                        w_nextCnt   = '0;
                    end else if (r_cnt >= DWELL_LAST) begin
                        w_nextIdx  = r_idx + N'(1);
                        w_nextOn   = 1'b1;
                        w_nextCnt  = '0;
                        w_nextWrap = (r_idx == IDX_LAST);
                    end else begin
                        w_nextOn  = 1'b1;
                        w_nextCnt = r_cnt + 8'd1;
                    end
                end
                default: begin
                    w_nextState = ST_IDLE;
                    w_nextIdx   = '0;
                    w_nextOn    = 1'b0;
                    w_nextCnt   = '0;
                end
            endcase
        end
    end

    dec_onehot #(.N(N)) u_onehot (
        .sel (w_nextIdx),
        .en  (w_nextOn),
        .y   (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_y     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_y     <= w_y;
            r_idx   <= w_nextIdx;
            r_cnt   <= w_nextCnt;
            r_wrap  <= w_nextWrap;
        end
    end

endmodule

// File: tb/tb_dec_scan.sv
// Testbench for dec_scan: N=2/DWELL=3 instance driven from a vector table plus
// hand sequences, and an N=1/DWELL=1 instance for toggle scanning and random one-hot checks.
module tb_dec_scan;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       enA, modeA, validA, readyA, wrapA, busyA;
    logic [1:0] iA, idxA;
    logic [3:0] yA;

    logic       enB, modeB, validB, readyB, wrapB, busyB;
    logic [0:0] iB, idxB;
    logic [1:0] yB;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        string      name;
        logic       en;
        logic       mode;
        logic       valid;
        logic [1:0] sel;
        logic [3:0] y;
        logic [1:0] idx;
        logic       wrap;
        logic       busy;
        logic       ready;
    } vec_t;

    vec_t vecs[$];

    dec_scan #(.N(2), .DWELL(3)) dutA (
        .clk(clk), .rst_n(rst_n), .en(enA), .mode(modeA), .in_valid(validA),
        .in_ready(readyA), .i(iA), .y(yA), .idx(idxA), .wrap(wrapA), .busy(busyA)
    );

    dec_scan #(.N(1), .DWELL(1)) dutB (
        .clk(clk), .rst_n(rst_n), .en(enB), .mode(modeB), .in_valid(validB),
        .in_ready(readyB), .i(iB), .y(yB), .idx(idxB), .wrap(wrapB), .busy(busyB)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic en, logic mode, logic valid, logic [1:0] sel,
                                logic [3:0] y, logic [1:0] idx, logic wrap, logic busy, logic ready);
        vec_t v;
        v.name = name; v.en = en; v.mode = mode; v.valid = valid; v.sel = sel;
        v.y = y; v.idx = idx; v.wrap = wrap; v.busy = busy; v.ready = ready;
        return v;
    endfunction

    // Drive instance A, then advance one clock and settle past the edge.
    task automatic applyStimulus(input logic en, input logic mode, input logic valid, input logic [1:0] sel);
        enA = en; modeA = mode; validA = valid; iA = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] packA();
        return {23'd0, readyA, busyA, wrapA, idxA, yA};
    endfunction

    function automatic logic [31:0] expA(logic ready, logic busy, logic wrap, logic [1:0] idx, logic [3:0] y);
        return {23'd0, ready, busy, wrap, idx, y};
    endfunction

    function automatic logic [31:0] packB();
        return {26'd0, readyB, busyB, wrapB, idxB, yB};
    endfunction

    initial begin
        logic [1:0] expYB [5];
        logic       expWB [5];
        logic       okB;

        enA = 0; modeA = 0; validA = 0; iA = 0;
        enB = 0; modeB = 0; validB = 0; iB = 0;
        rst_n = 1'b0;
        #3;
        checkOutput("resetA", packA(), 32'd0);
        checkOutput("resetB", packB(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++)
            vecs.push_back(mk("enOff", 0, 0, 1, 2'(k), 4'b0000, 2'd0, 0, 0, 0));
        vecs.push_back(mk("enterDirect", 1, 0, 0, 2'd0, 4'b0000, 2'd0, 0, 0, 1));
        vecs.push_back(mk("dir00", 1, 0, 1, 2'd0, 4'b0001, 2'd0, 0, 0, 1));
        vecs.push_back(mk("dir01", 1, 0, 1, 2'd1, 4'b0010, 2'd1, 0, 0, 1));
        vecs.push_back(mk("dir10", 1, 0, 1, 2'd2, 4'b0100, 2'd2, 0, 0, 1));
        vecs.push_back(mk("dir11", 1, 0, 1, 2'd3, 4'b1000, 2'd3, 0, 0, 1));
        vecs.push_back(mk("dirHold", 1, 0, 0, 2'd2, 4'b1000, 2'd3, 0, 0, 1));
        vecs.push_back(mk("enFallHs", 0, 0, 1, 2'd1, 4'b0000, 2'd0, 0, 0, 0));
        // Scan with DWELL=3: three cycles per bit, wrap on the 13th cycle; in_valid/i are noise.
        vecs.push_back(mk("scan01", 1, 1, 1, 2'd3, 4'b0001, 2'd0, 0, 1, 0));
        vecs.push_back(mk("scan02", 1, 1, 1, 2'd2, 4'b0001, 2'd0, 0, 1, 0));
        vecs.push_back(mk("scan03", 1, 1, 0, 2'd0, 4'b0001, 2'd0, 0, 1, 0));
        vecs.push_back(mk("scan04", 1, 1, 1, 2'd0, 4'b0010, 2'd1, 0, 1, 0));
        vecs.push_back(mk("scan05", 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0, 1, 0));
        vecs.push_back(mk("scan06", 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0, 1, 0));
        vecs.push_back(mk("scan07", 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0, 1, 0));
        vecs.push_back(mk("scan08", 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0, 1, 0));
        vecs.push_back(mk("scan09", 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0, 1, 0));
        vecs.push_back(mk("scan10", 1, 1, 0, 2'd0, 4'b1000, 2'd3, 0, 1, 0));
        vecs.push_back(mk("scan11", 1, 1, 0, 2'd0, 4'b1000, 2'd3, 0, 1, 0));
        vecs.push_back(mk("scan12", 1, 1, 0, 2'd0, 4'b1000, 2'd3, 0, 1, 0));
        vecs.push_back(mk("scan13wrap", 1, 1, 0, 2'd0, 4'b0001, 2'd0, 1, 1, 0));
        vecs.push_back(mk("scan14", 1, 1, 0, 2'd0, 4'b0001, 2'd0, 0, 1, 0));
        vecs.push_back(mk("scan15", 1, 1, 0, 2'd0, 4'b0001, 2'd0, 0, 1, 0));
        vecs.push_back(mk("scan16", 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0, 1, 0));
        vecs.push_back(mk("scan17", 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0, 1, 0));
        vecs.push_back(mk("scan18", 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0, 1, 0));
        vecs.push_back(mk("scan19", 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0, 1, 0));
        vecs.push_back(mk("scan20", 1, 1, 0, 2'd0, 4'b0100, 2'd2, 0, 1, 0));
        vecs.push_back(mk("scanCut", 1, 0, 0, 2'd0, 4'b0000, 2'd0, 0, 0, 1));
        vecs.push_back(mk("dirAfterCut", 1, 0, 1, 2'd3, 4'b1000, 2'd3, 0, 0, 1));
        vecs.push_back(mk("dirToScan", 1, 1, 1, 2'd2, 4'b0001, 2'd0, 0, 1, 0));
        vecs.push_back(mk("scanIgnore", 1, 1, 1, 2'd1, 4'b0001, 2'd0, 0, 1, 0));
        vecs.push_back(mk("scanDwell3", 1, 1, 0, 2'd0, 4'b0001, 2'd0, 0, 1, 0));
        vecs.push_back(mk("scanAdv", 1, 1, 0, 2'd0, 4'b0010, 2'd1, 0, 1, 0));
        vecs.push_back(mk("enOffScan", 0, 1, 0, 2'd0, 4'b0000, 2'd0, 0, 0, 0));

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].en, vecs[n].mode, vecs[n].valid, vecs[n].sel);
            checkOutput(vecs[n].name, packA(),
                        expA(vecs[n].ready, vecs[n].busy, vecs[n].wrap, vecs[n].idx, vecs[n].y));
        end

        // Reset held with scan requested; first edge after release enters scan.
        rst_n = 1'b0;
        enA = 1; modeA = 1; validA = 0; iA = 0;
        #1;
        checkOutput("rstHeld", packA(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 1, 0, 2'd0);
        checkOutput("relFirstEdge", packA(), expA(0, 1, 0, 2'd0, 4'b0001));
        for (int k = 0; k < 12; k++)
            applyStimulus(1, 1, 0, 2'd0);
        checkOutput("wrapBeforeRst", packA(), expA(0, 1, 1, 2'd0, 4'b0001));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstMidScan", packA(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        enA = 0; modeA = 0;

        // N=1, DWELL=1 toggle scan.
        expYB = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        expWB = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        enB = 1; modeB = 1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("n1scan%0d", k), packB(),
                        {26'd0, 1'b0, 1'b1, expWB[k], 1'(k % 2), expYB[k]});
        end

        for (int k = 0; k < 200; k++) begin
            enB    = 1'($urandom_range(0, 7) != 0);
            modeB  = 1'($urandom_range(0, 1));
            validB = 1'($urandom_range(0, 1));
            iB     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            okB = ($countones(yB) <= 1) &&
                  ((yB == 2'b00) ? (idxB == 1'b0) : (yB == (2'b01 << idxB))) &&
                  (!wrapB || busyB);
            checkOutput("n1randOneHot", {31'd0, okB}, 32'd1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
